pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Inverse of the one-pulse conditioner. Takes single-cycle enable strobes (e.g. Clk_EN) and turns each into a fixed-width, human/scope-visible level pulse for LEDs or slow downstream logic.
- Separates successive stretched pulses with a guaranteed low gap.
- Queues strobes that arrive while busy in a saturating pending counter, so no event is silently merged.

Parameters:
- HOLD_CYCLES, 8, clocks level_out stays high per strobe; must be >= 1.
- GAP_CYCLES, 2, minimum clocks level_out stays low between stretched pulses; must be >= 1.
- PEND_W, 3, width of the pending-strobe counter; max queued = 2^PEND_W - 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- pulse_in  input  1  single-cycle strobe, sampled each rising edge; multi-cycle high counts as one strobe per cycle.
- level_out  output  1  registered stretched pulse.
- busy  output  1  high in HOLD or GAP.
- pend_cnt  output  PEND_W  queued strobes not yet emitted.
- overflow  output  1  sticky; set when a strobe is dropped at saturation; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; level_out=0, busy=0, pend_cnt=0, overflow=0; hold/gap counters 0. Takes effect immediately, including mid-HOLD/GAP; the stretched pulse is truncated with no completion.
- States: IDLE, HOLD, GAP. All outputs registered from state and counters.
- IDLE:
  - pulse_in=1 at edge E -> HOLD. level_out=1 after E. busy=1.
  - pulse_in=0 -> stay in IDLE.
- HOLD:
  - level_out=1 for exactly HOLD_CYCLES clocks (after E through edge E+HOLD_CYCLES).
  - At edge E+HOLD_CYCLES -> GAP, level_out=0.
- GAP:
  - level_out=0 for exactly GAP_CYCLES clocks.
  - On the last GAP edge, if pend_cnt>0 or pulse_in=1 -> HOLD (new pulse). Otherwise -> IDLE, busy=0.
- Pending counter:
  - A strobe sampled in HOLD or GAP increments pend_cnt.
  - Launching a HOLD from GAP consumes one: the new pend_cnt = pend_cnt + pulse_in - 1.
  - A strobe arriving on the launching edge with pend_cnt=0 is consumed directly; pend_cnt stays 0.
  - If pend_cnt = max and a strobe arrives with no simultaneous consume: pend_cnt holds at max and overflow <= 1.
  - A simultaneous strobe and consume at max leaves pend_cnt at max with no overflow.
- Latency: strobe to level_out rising is 1 clock when idle.
- Throughput: one stretched pulse per HOLD_CYCLES+GAP_CYCLES clocks.
- Counters:
  - Hold and gap counters use $clog2-sized widths, with a minimum of 1 bit.
  - Counters count down and reload on state entry. No wrap-around is possible because they reload before reaching 0-1.

Optional Feature:
- Macro: PULSE_STRETCHER_RETRIGGER_EN.
- Defined: a strobe sampled during HOLD reloads the hold counter to HOLD_CYCLES; level_out stays high HOLD_CYCLES clocks past the latest strobe. It is not queued; pend_cnt is unaffected. Strobes during GAP still queue as normal.
- Undefined: HOLD strobes queue as described in Behaviour.

Test Plan (HOLD_CYCLES=8, GAP_CYCLES=2, PEND_W=3):
1. Reset: hold rst=0 for 3 clocks with pulse_in toggling -> level_out=0, busy=0, pend_cnt=0, overflow=0 throughout; release, still idle.
2. Single strobe at edge 10 -> level_out high after edge 10 through edge 18 (8 clocks); low edges 18–20; busy=0 after edge 20.
3. Strobes at edges 10, 11, 12 -> pend_cnt goes 1, 2. Output is three 8-high/2-low trains (rises after edges 10, 20, 30). pend_cnt reads 1 after edge 20 and 0 after edge 30. overflow=0.
4. Strobe on every edge 10..19 (10 strobes) -> pend_cnt saturates at 7 and overflow=1 from edge 18. Exactly 8 stretched pulses emitted; overflow remains 1 afterwards.
5. Reset mid-operation: strobes at 10 and 11, rst=0 asserted mid-cycle at 14.5 -> level_out=0, pend_cnt=0 immediately, before edge 15. After release, no further pulses.
6. With PULSE_STRETCHER_RETRIGGER_EN: strobes at edges 10 and 15 -> level_out high after edge 10 through edge 23 (13 clocks), single pulse; pend_cnt stays 0. Without the macro, the same stimulus gives two 8-clock pulses with a 2-clock gap.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into HOLD_CYCLES-high pulses separated by at least GAP_CYCLES low.
// Optional macro PULSE_STRETCHER_RETRIGGER_EN: a strobe during HOLD restarts the hold window instead of queueing.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0]     HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0]     GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [HW-1:0]     HOLD_ZERO = {HW{1'b0}};
  localparam logic [GW-1:0]     GAP_ZERO  = {GW{1'b0}};
  localparam logic [HW-1:0]     HOLD_ONE  = HW'(1);
  localparam logic [GW-1:0]     GAP_ONE   = GW'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [PEND_W-1:0] pend_cnt_q, pend_cnt_d;
  logic              overflow_q, overflow_d;
  logic              level_q, level_d;
  logic              busy_q, busy_d;
  logic              inc_s;
  logic              dec_s;

  // Next-state, countdown and pending-queue logic
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pend_cnt_d = pend_cnt_q;
    overflow_d = overflow_q;
    inc_s      = 1'b0;
    dec_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (pulse_in) begin
          hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q == HOLD_ZERO) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
`else
        inc_s = pulse_in;
        if (hold_cnt_q == HOLD_ZERO) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
`endif
      end
      GAP: begin
        inc_s = pulse_in;
        if (gap_cnt_q != GAP_ZERO) begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end else if ((pend_cnt_q != PEND_ZERO) || pulse_in) begin
          // Launching consumes one queued strobe; a same-edge strobe with an empty queue nets to zero.
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
          dec_s      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = HOLD_ZERO;
        gap_cnt_d  = GAP_ZERO;
      end
    endcase

    if (inc_s && !dec_s) begin
      if (pend_cnt_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pend_cnt_d = pend_cnt_q + PEND_ONE;
      end
    end else if (!inc_s && dec_s) begin
      pend_cnt_d = pend_cnt_q - PEND_ONE;
    end else begin
      pend_cnt_d = pend_cnt_q;
    end

    level_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs; reset truncates any pulse in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= HOLD_ZERO;
      gap_cnt_q  <= GAP_ZERO;
      pend_cnt_q <= PEND_ZERO;
      overflow_q <= 1'b0;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pend_cnt_q <= pend_cnt_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pend_cnt  = pend_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: per-cycle compare against an edge-index timeline model,
// plus directed scenarios with hand-computed expectations. Honours PULSE_STRETCHER_RETRIGGER_EN.
module tb_pulse_stretcher;

  localparam int H    = 8;
  localparam int G    = 2;
  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse_in = 1'b0;
  logic          level_out;
  logic          busy;
  logic [PW-1:0] pend_cnt;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in),
    .level_out(level_out), .busy(busy), .pend_cnt(pend_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a pulse launched at edge s is high until edge hold_end and busy until gap_end.
  int m_t, m_hold_end, m_gap_end, m_pend;
  bit m_act, m_ovf;

  task automatic m_launch(input int t);
    m_act      = 1'b1;
    m_hold_end = t + H;
    m_gap_end  = t + H + G;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t = 0; m_act = 1'b0; m_pend = 0; m_ovf = 1'b0; m_hold_end = 0; m_gap_end = 0;
    end else begin
      m_t++;
      if (!m_act) begin
        if (pulse_in) m_launch(m_t);
      end else if (m_t == m_gap_end) begin
        if (m_pend > 0 || pulse_in) begin
          m_pend = m_pend + int'(pulse_in) - 1;
          m_launch(m_t);
        end else begin
          m_act = 1'b0;
        end
      end else if (RETRIG && pulse_in && m_t <= m_hold_end) begin
        m_hold_end = m_t + H;
        m_gap_end  = m_hold_end + G;
      end else if (pulse_in) begin
        if (m_pend == PMAX) m_ovf = 1'b1;
        else m_pend++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level_out", int'(level_out), int'(m_act && (m_t < m_hold_end)));
      chk("busy", int'(busy), int'(m_act));
      chk("pend_cnt", int'(pend_cnt), m_pend);
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  logic          lvl_tr [0:127];
  logic          busy_tr[0:127];
  logic          ovf_tr [0:127];
  logic [PW-1:0] pend_tr[0:127];
  int rises, highs;

  // Applies mask bit i before relative edge i and records outputs just after it.
  task automatic run_pattern(input logic [127:0] mask, input int ncyc);
    rises = 0; highs = 0;
    for (int i = 0; i < ncyc; i++) begin
      pulse_in = mask[i];
      @(posedge clk); #1;
      lvl_tr[i] = level_out; busy_tr[i] = busy; ovf_tr[i] = overflow; pend_tr[i] = pend_cnt;
      if (level_out) highs++;
      if (level_out && (i == 0 || !lvl_tr[i-1])) rises++;
    end
    pulse_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, int'(level_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pend"}, int'(pend_cnt), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  // Hold reset over three edges with pulse_in toggling, then release on a falling edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_in = ~pulse_in;
      @(posedge clk); #1;
      check_zero("rst_hold");
    end
    pulse_in = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic mid_reset();
    #3 rst = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1;
  endtask

  logic [127:0] mask;

  initial begin
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;

    // Reset, then remain idle after release
    do_reset();
    run_pattern(128'd0, 5);
    check_zero("post_rst_idle");

    // Single strobe at edge 10
    mask = 128'd0; mask[10] = 1'b1;
    run_pattern(mask, 30);
    chk("single_pre", int'(lvl_tr[9]), 0);
    chk("single_rise", int'(lvl_tr[10]), 1);
    chk("single_last_high", int'(lvl_tr[17]), 1);
    chk("single_fall", int'(lvl_tr[18]), 0);
    chk("single_busy_gap", int'(busy_tr[19]), 1);
    chk("single_idle", int'(busy_tr[20]), 0);
    chk("single_highs", highs, H);

    // Three back-to-back strobes
    do_reset();
    mask = 128'd0; mask[10] = 1'b1; mask[11] = 1'b1; mask[12] = 1'b1;
    run_pattern(mask, 45);
    chk("burst3_pend11", int'(pend_tr[11]), 1);
    chk("burst3_pend12", int'(pend_tr[12]), 2);
    chk("burst3_pend20", int'(pend_tr[20]), 1);
    chk("burst3_pend30", int'(pend_tr[30]), 0);
    chk("burst3_rise20", int'(lvl_tr[20]), 1);
    chk("burst3_rise30", int'(lvl_tr[30]), 1);
    chk("burst3_rises", rises, 3);
    chk("burst3_ovf", int'(ovf_tr[44]), 0);

    // Saturation: strobes on edges 10..19
    do_reset();
    mask = 128'd0;
    for (int i = 10; i <= 19; i++) mask[i] = 1'b1;
    run_pattern(mask, 100);
    chk("sat_pend17", int'(pend_tr[17]), PMAX);
    chk("sat_ovf17", int'(ovf_tr[17]), 0);
    chk("sat_ovf18", int'(ovf_tr[18]), 1);
    chk("sat_rises", rises, 8);
    chk("sat_ovf_sticky", int'(ovf_tr[99]), 1);

    // Asynchronous reset mid-pulse
    do_reset();
    mask = 128'd0; mask[10] = 1'b1; mask[11] = 1'b1;
    run_pattern(mask, 15);
    chk("midrst_pre_level", int'(lvl_tr[14]), 1);
    mid_reset();
    run_pattern(128'd0, 30);
    chk("midrst_no_pulses", rises, 0);

    // Retrigger scenario: strobes at edges 10 and 15
    do_reset();
    mask = 128'd0; mask[10] = 1'b1; mask[15] = 1'b1;
    run_pattern(mask, 40);
    if (RETRIG) begin
      chk("retrig_rises", rises, 1);
      chk("retrig_highs", highs, 13);
      chk("retrig_pend15", int'(pend_tr[15]), 0);
      chk("retrig_last_high", int'(lvl_tr[22]), 1);
      chk("retrig_fall", int'(lvl_tr[23]), 0);
    end else begin
      chk("retrig_rises", rises, 2);
      chk("retrig_highs", highs, 2 * H);
      chk("retrig_pend15", int'(pend_tr[15]), 1);
      chk("retrig_gap", int'(lvl_tr[19]), 0);
      chk("retrig_second", int'(lvl_tr[20]), 1);
    end

    // Random strobes with varying density and occasional mid-cycle resets
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        pulse_in = ($urandom_range(0, 99) < dens);
        @(posedge clk); #1;
        if ($urandom_range(0, 399) == 0) begin
          pulse_in = 1'b0;
          mid_reset();
        end
      end
    end
    pulse_in = 1'b0;
    run_pattern(128'd0, 120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
